// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared definitions for the staged reset release sequencer:
//               FSM state encoding, counter/index width helpers and the
//               parameter legality check used at elaboration.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // FSM state encoding
    localparam logic [1:0] HOLD  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    // Width of the shared settle/timeout counter: it must hold max(DELAY, TIMEOUT).
    function automatic int cnt_width(input int delay, input int timeout);
        int m;
        m = (delay > timeout) ? delay : timeout;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    // Width of the stage index / fault_stage output.
    function automatic int idx_width(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

    function automatic bit params_ok(input int stages, input int delay, input int timeout);
        return (delay >= 1) && (stages >= 1) && (stages <= 16) && (timeout >= 0);
    endfunction

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/reset_seq_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop single-bit synchronizer with synchronous clear.
// Ports       : clock - destination clock
//               reset - synchronous active-high clear of both flops
//               d     - asynchronous input bit
//               q     - synchronized output bit
// Revision    : 1.0 - initial release
// ============================================================================
module sync2
    import reset_seq_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta <= 1'b0;
            q      <= 1'b0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule : sync2
`default_nettype wire

// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq
// Description : Staged reset release sequencer. Releases STAGES downstream
//               reset domains in ascending order; each release is preceded
//               by DELAY settling cycles and followed by a wait for that
//               stage's ready. A missing ready (TIMEOUT cycles, 0 = forever)
//               latches a fault until reset.
// Ports       : clock       - single clock, rising edge
//               reset       - synchronous active-high reset
//               ready       - per-stage acknowledge, asynchronous
//               stage_reset - registered active-high reset per stage
//               done        - every stage released and acknowledged
//               fault       - sequence aborted, latched until reset
//               fault_stage - index of the stage that faulted
// Config      : RESET_SEQ_MONITOR_EN - when defined, a drop of ready on an
//               already acknowledged stage forces FAULT.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int STAGES  = 4,
    parameter int DELAY   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [STAGES-1:0]               ready,
    output logic [STAGES-1:0]               stage_reset,
    output logic                            done,
    output logic                            fault,
    output logic [idx_width(STAGES)-1:0]    fault_stage
);

    localparam int c_idx_w = idx_width(STAGES);
    localparam int c_cnt_w = cnt_width(DELAY, TIMEOUT);

    localparam logic [c_cnt_w-1:0] c_delay_last   = c_cnt_w'(DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_cnt_max      = {c_cnt_w{1'b1}};
    localparam logic [c_idx_w-1:0] c_last_idx     = c_idx_w'(STAGES - 1);

    generate
        if (!params_ok(STAGES, DELAY, TIMEOUT)) begin : g_bad_params
            $error("reset_seq: illegal parameters (need DELAY>=1, 1<=STAGES<=16, TIMEOUT>=0)");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_cnt_w-1:0]  r_cnt;

    logic [STAGES-1:0]   w_ready_s;
    logic [STAGES-1:0]   w_sync_clr;
    logic                w_drop_any;
    logic [c_idx_w-1:0]  w_drop_idx;

    // A stage's acknowledge is only believed once its own reset has been
    // released, so each synchronizer is also held clear while its stage is
    // in reset. A ready that is already high before release is therefore
    // seen two cycles after the release, like any fresh ready edge.
    assign w_sync_clr = {STAGES{reset}} | stage_reset;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_sync
            sync2 u_sync2 (
                .clock (clock),
                .reset (w_sync_clr[gi]),
                .d     (ready[gi]),
                .q     (w_ready_s[gi])
            );
        end
    endgenerate

`ifdef RESET_SEQ_MONITOR_EN
    logic [STAGES-1:0] w_acked;
    logic [STAGES-1:0] w_dropped;

    // Stages below idx have acknowledged; in DONE all of them have.
    always_comb begin
        w_acked = '0;
        for (int i = 0; i < STAGES; i++) begin
            if ((r_state == DONE) ||
                (((r_state == HOLD) || (r_state == WAIT)) && (c_idx_w'(i) < r_idx))) begin
                w_acked[i] = 1'b1;
            end
        end
    end

    assign w_dropped = w_acked & ~w_ready_s;

    // Descending scan so the lowest dropped index wins.
    always_comb begin
        w_drop_any = |w_dropped;
        w_drop_idx = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (w_dropped[i]) begin
                w_drop_idx = c_idx_w'(i);
            end
        end
    end
`else
    assign w_drop_any = 1'b0;
    assign w_drop_idx = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= HOLD;
            r_idx       <= '0;
            r_cnt       <= '0;
            stage_reset <= '1;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_stage <= '0;
        end else if (w_drop_any) begin
            // A drop outranks a same-cycle timeout.
            r_state     <= FAULT;
            stage_reset <= '1;
            done        <= 1'b0;
            fault       <= 1'b1;
            fault_stage <= w_drop_idx;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == c_delay_last) begin
                        stage_reset[r_idx] <= 1'b0;
                        r_state            <= WAIT;
                        r_cnt              <= '0;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (w_ready_s[r_idx]) begin
                        if (r_idx == c_last_idx) begin
                            r_state     <= DONE;
                            done        <= 1'b1;
                            stage_reset <= '0;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= HOLD;
                            r_cnt   <= '0;
                        end
                    end else if ((TIMEOUT != 0) && (r_cnt == c_timeout_last)) begin
                        r_state     <= FAULT;
                        stage_reset <= '1;
                        done        <= 1'b0;
                        fault       <= 1'b1;
                        fault_stage <= r_idx;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE and FAULT hold until reset.
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule : reset_seq
`default_nettype wire

// File: tb/tb_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_seq
// Description : Self-checking bench for reset_seq (STAGES=3, DELAY=4,
//               TIMEOUT=10). Expected output vectors are queued with the
//               cycle they belong to when stimulus is planned, and popped
//               and compared on the falling clock edge of that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_seq;

    localparam int STAGES  = 3;
    localparam int DELAY   = 4;
    localparam int TIMEOUT = 10;

    logic        clock;
    logic        reset;
    logic [2:0]  ready;
    logic [2:0]  stage_reset;
    logic        done;
    logic        fault;
    logic [1:0]  fault_stage;

    reset_seq #(
        .STAGES  (STAGES),
        .DELAY   (DELAY),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .ready       (ready),
        .stage_reset (stage_reset),
        .done        (done),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    int base = 0;
    int n_tests = 0;
    int n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue one expected {stage_reset, done, fault, fault_stage} at cycle rel.
    task automatic expect_at(input int rel, input logic [2:0] sr, input logic dn,
                             input logic ft, input logic [1:0] fs, input string tag);
        exp_t e;
        e.cyc = base + rel;
        e.val = {25'd0, sr, dn, ft, fs};
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    always @(negedge clock) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < cyc)
                chk({e.tag, "_cycle"}, cyc, e.cyc);
            else
                chk(e.tag, {25'd0, stage_reset, done, fault, fault_stage}, e.val);
        end
    end

    // Advance to relative cycle rel (just after its opening clock edge).
    task automatic at(input int rel);
        while (cyc < base + rel) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start_seq();
        @(posedge clock);
        #1;
        reset = 1'b1;
        ready = '0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        base  = cyc;
    endtask

    // One-cycle reset pulse in relative cycle rel; cycle 0 restarts after it.
    task automatic pulse_reset(input int rel);
        at(rel);
        reset = 1'b1;
        ready = '0;
        at(rel + 1);
        reset = 1'b0;
        base  = cyc;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() > 0 && k < 400) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    // Nominal run from cycle 0: ready[i] two cycles after stage_reset[i] falls.
    task automatic run_nominal(input string p);
        expect_at(0,  3'b111, 1'b0, 1'b0, 2'd0, {p, "_c0"});
        expect_at(3,  3'b111, 1'b0, 1'b0, 2'd0, {p, "_c3"});
        expect_at(4,  3'b110, 1'b0, 1'b0, 2'd0, {p, "_c4"});
        expect_at(12, 3'b110, 1'b0, 1'b0, 2'd0, {p, "_c12"});
        expect_at(13, 3'b100, 1'b0, 1'b0, 2'd0, {p, "_c13"});
        expect_at(21, 3'b100, 1'b0, 1'b0, 2'd0, {p, "_c21"});
        expect_at(22, 3'b000, 1'b0, 1'b0, 2'd0, {p, "_c22"});
        expect_at(26, 3'b000, 1'b0, 1'b0, 2'd0, {p, "_c26"});
        expect_at(27, 3'b000, 1'b1, 1'b0, 2'd0, {p, "_c27"});
        at(6);  ready[0] = 1'b1;
        at(15); ready[1] = 1'b1;
        at(24); ready[2] = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ready = '0;

        // Nominal sequence, then drop ready[0] for 3 cycles while in DONE.
        start_seq();
        run_nominal("nom");
`ifdef RESET_SEQ_MONITOR_EN
        expect_at(32, 3'b000, 1'b1, 1'b0, 2'd0, "mon_c32");
        expect_at(33, 3'b111, 1'b0, 1'b1, 2'd0, "mon_fault");
        expect_at(40, 3'b111, 1'b0, 1'b1, 2'd0, "mon_hold");
`else
        expect_at(33, 3'b000, 1'b1, 1'b0, 2'd0, "mon_c33");
        expect_at(40, 3'b000, 1'b1, 1'b0, 2'd0, "mon_c40");
`endif
        at(30); ready[0] = 1'b0;
        at(33); ready[0] = 1'b1;
        drain();

        // Timeout on stage 1: WAIT entered at 13, fault at 23, held 100 cycles.
        start_seq();
        expect_at(13,  3'b100, 1'b0, 1'b0, 2'd0, "to_c13");
        expect_at(22,  3'b100, 1'b0, 1'b0, 2'd0, "to_c22");
        expect_at(23,  3'b111, 1'b0, 1'b1, 2'd1, "to_fault");
        expect_at(60,  3'b111, 1'b0, 1'b1, 2'd1, "to_c60");
        expect_at(123, 3'b111, 1'b0, 1'b1, 2'd1, "to_c123");
        at(6); ready[0] = 1'b1;
        drain();

        // Boundary: ready_s[0] first high in cycle 13, the last WAIT cycle.
        start_seq();
        expect_at(13, 3'b110, 1'b0, 1'b0, 2'd0, "bnd_ok_c13");
        expect_at(14, 3'b110, 1'b0, 1'b0, 2'd0, "bnd_ok_c14");
        expect_at(17, 3'b110, 1'b0, 1'b0, 2'd0, "bnd_ok_c17");
        expect_at(18, 3'b100, 1'b0, 1'b0, 2'd0, "bnd_ok_c18");
        at(11); ready[0] = 1'b1;
        drain();

        // Boundary: ready_s[0] first high one cycle too late.
        start_seq();
        expect_at(13, 3'b110, 1'b0, 1'b0, 2'd0, "bnd_late_c13");
        expect_at(14, 3'b111, 1'b0, 1'b1, 2'd0, "bnd_late_fault");
        at(12); ready[0] = 1'b1;
        drain();

        // Reset pulse while waiting on stage 2, then a full nominal run.
        start_seq();
        expect_at(4,  3'b110, 1'b0, 1'b0, 2'd0, "rmid_c4");
        expect_at(13, 3'b100, 1'b0, 1'b0, 2'd0, "rmid_c13");
        expect_at(22, 3'b000, 1'b0, 1'b0, 2'd0, "rmid_c22");
        at(6);  ready[0] = 1'b1;
        at(15); ready[1] = 1'b1;
        pulse_reset(23);
        run_nominal("rmid_re");
        drain();

        // Reset pulse while in FAULT, then a full nominal run.
        start_seq();
        expect_at(23, 3'b111, 1'b0, 1'b1, 2'd1, "rflt_fault");
        at(6); ready[0] = 1'b1;
        pulse_reset(30);
        run_nominal("rflt_re");
        drain();

        // Early ready: all ready tied high from cycle 0.
        start_seq();
        ready = 3'b111;
        expect_at(3,  3'b111, 1'b0, 1'b0, 2'd0, "early_c3");
        expect_at(4,  3'b110, 1'b0, 1'b0, 2'd0, "early_c4");
        expect_at(10, 3'b110, 1'b0, 1'b0, 2'd0, "early_c10");
        expect_at(11, 3'b100, 1'b0, 1'b0, 2'd0, "early_c11");
        expect_at(17, 3'b100, 1'b0, 1'b0, 2'd0, "early_c17");
        expect_at(18, 3'b000, 1'b0, 1'b0, 2'd0, "early_c18");
        expect_at(20, 3'b000, 1'b0, 1'b0, 2'd0, "early_c20");
        expect_at(21, 3'b000, 1'b1, 1'b0, 2'd0, "early_done");
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_reset_seq
`default_nettype wire
